uart_rx_frame_checker: RTL

- Parametrised receive-side frame checker for the UART path.
- Sits after the bit sampler and consumes one sampled bit per `bit_valid` strobe after a detected start bit.
- Assembles a data word of configurable width and checks parity in a runtime-selectable mode (none/even/odd/mark) and 1 or 2 stop bits.
- Reports per-frame parity and framing errors and keeps saturating error counters for status readout.

---
 rtl/uart_rx_frame_checker_if.sv | 31 +++
 rtl/uart_rx_frame_checker.sv | 135 +++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_checker_if.sv
// Sampler-side handshake and status bundle for the UART receive frame checker.
// master: bit sampler / status reader; slave: the frame checker.
interface uart_rx_frame_checker_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
);
  logic                  frame_start;
  logic                  bit_valid;
  logic                  bit_in;
  logic [1:0]            parity_mode;
  logic                  clear_counts;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  parity_err;
  logic                  frame_err;
  logic                  busy;
  logic [CNT_WIDTH-1:0]  parity_err_count;
  logic [CNT_WIDTH-1:0]  frame_err_count;

  modport master (
    output frame_start, bit_valid, bit_in, parity_mode, clear_counts,
    input  data_out, data_valid, parity_err, frame_err, busy,
           parity_err_count, frame_err_count
  );

  modport slave (
    input  frame_start, bit_valid, bit_in, parity_mode, clear_counts,
    output data_out, data_valid, parity_err, frame_err, busy,
           parity_err_count, frame_err_count
  );
endinterface

// File: rtl/uart_rx_frame_checker.sv
// UART receive frame checker: assembles data bits after a start bit, checks
// parity (none/even/odd/mark) and stop bits, keeps saturating error counters.
module uart_rx_frame_checker #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int CNT_WIDTH  = 8
) (
  input logic                    Clk,
  input logic                    reset_n,
  uart_rx_frame_checker_if.slave rx
);
  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t                state_reg;
  logic [1:0]            mode_reg;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] data_out_reg;
  logic [IDX_W-1:0]      count_reg;
  logic                  parity_reg;
  logic                  perr_pend_reg;
  logic                  ferr_pend_reg;
  logic                  stop_cnt_reg;
  logic                  data_valid_reg;
  logic                  parity_err_reg;
  logic                  frame_err_reg;
  logic                  busy_reg;
  logic [CNT_WIDTH-1:0]  perr_cnt_reg;
  logic [CNT_WIDTH-1:0]  ferr_cnt_reg;

  logic expected_parity;
  logic last_stop;
  logic done;
  logic perr_final;
  logic ferr_final;

  always_comb begin
    case (mode_reg)
      2'b01:   expected_parity = parity_reg;
      2'b10:   expected_parity = ~parity_reg;
      default: expected_parity = 1'b1;
    endcase
    last_stop  = (stop_cnt_reg == 1'(STOP_BITS - 1));
    done       = (state_reg == STOP) && rx.bit_valid && last_stop;
    perr_final = perr_pend_reg && (mode_reg != 2'b00);
    // The final stop bit is folded in directly since it is never registered.
    ferr_final = ferr_pend_reg || !rx.bit_in;
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      mode_reg       <= 2'b00;
      shift_reg      <= '0;
      data_out_reg   <= '0;
      count_reg      <= '0;
      parity_reg     <= 1'b0;
      perr_pend_reg  <= 1'b0;
      ferr_pend_reg  <= 1'b0;
      stop_cnt_reg   <= 1'b0;
      data_valid_reg <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      busy_reg       <= 1'b0;
      perr_cnt_reg   <= '0;
      ferr_cnt_reg   <= '0;
    end else begin
      data_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // A bit_valid coinciding with frame_start is the start bit itself.
          if (rx.frame_start) begin
            mode_reg      <= rx.parity_mode;
            count_reg     <= '0;
            parity_reg    <= 1'b0;
            perr_pend_reg <= 1'b0;
            ferr_pend_reg <= 1'b0;
            stop_cnt_reg  <= 1'b0;
            busy_reg      <= 1'b1;
            state_reg     <= DATA;
          end
        end
        DATA: begin
          if (rx.bit_valid) begin
            shift_reg[count_reg] <= rx.bit_in;
            parity_reg           <= parity_reg ^ rx.bit_in;
            if (count_reg == IDX_W'(DATA_WIDTH - 1)) begin
              state_reg <= (mode_reg == 2'b00) ? STOP : PARITY;
            end else begin
              count_reg <= count_reg + IDX_W'(1);
            end
          end
        end
        PARITY: begin
          if (rx.bit_valid) begin
            if (rx.bit_in != expected_parity) perr_pend_reg <= 1'b1;
            state_reg <= STOP;
          end
        end
        STOP: begin
          if (done) begin
            state_reg      <= IDLE;
            busy_reg       <= 1'b0;
            data_valid_reg <= 1'b1;
            data_out_reg   <= shift_reg;
            parity_err_reg <= perr_final;
            frame_err_reg  <= ferr_final;
          end else if (rx.bit_valid) begin
            stop_cnt_reg <= 1'b1;
            if (!rx.bit_in) ferr_pend_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase

      if (rx.clear_counts) begin
        perr_cnt_reg <= '0;
        ferr_cnt_reg <= '0;
      end else if (done) begin
        if (perr_final && perr_cnt_reg != CNT_MAX) perr_cnt_reg <= perr_cnt_reg + CNT_WIDTH'(1);
        if (ferr_final && ferr_cnt_reg != CNT_MAX) ferr_cnt_reg <= ferr_cnt_reg + CNT_WIDTH'(1);
      end
    end
  end

  assign rx.data_out         = data_out_reg;
  assign rx.data_valid       = data_valid_reg;
  assign rx.parity_err       = parity_err_reg;
  assign rx.frame_err        = frame_err_reg;
  assign rx.busy             = busy_reg;
  assign rx.parity_err_count = perr_cnt_reg;
  assign rx.frame_err_count  = ferr_cnt_reg;
endmodule
